multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control FSM that sequences the core datapath (register file, ALU, sign extender, program counter) over several clock cycles per instruction instead of one. It sits between a shared instruction/data memory port and the datapath. It drives the existing strobes (regwrite, alusrc, immsrc, pcsrc) plus fetch, memory and instruction-register enables. Memory accesses use a req/ready handshake, so a single memory can serve both fetch and load/store.

## Interface
- `XLEN`, default 32: width of the retired-instruction counter.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-low reset.
- `opcode`  input  7  instr[6:0] taken from the instruction register.
- `funct3`  input  3  instr[14:12] taken from the instruction register.
- `eq`  input  1  ALU equality flag (rs1 == rs2).
- `mem_ready`  input  1  memory accepts or completes the current request.
- `mem_req`  output  1  memory request; held high until `mem_ready` is seen.
- `mem_we`  output  1  write qualifier for `mem_req`.
- `ir_we`  output  1  instruction register load enable.
- `pc_we`  output  1  PC update enable.
- `pcsrc`  output  1  0 selects PC+4, 1 selects PC_old+ImmOp.
- `regwrite`  output  1  register file write enable.
- `alusrc`  output  1  0 selects rs2, 1 selects ImmOp.
- `immsrc`  output  2  00 = I, 01 = S, 10 = B.
- `result_src`  output  1  0 selects ALU result, 1 selects memory read data.
- `illegal`  output  1  sticky; unsupported opcode seen.
- `retired`  output  XLEN  count of retired instructions.

## Operation
- States: START, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Reset:
  - Asynchronous assert goes to START.
  - START drives every output 0 and `retired` = 0.
  - START → FETCH unconditionally on the next edge.
- FETCH:
  - Drives `mem_req`=1 and `mem_we`=0.
  - Stays in FETCH while `mem_ready`=0.
  - In the cycle `mem_ready`=1, pulses `ir_we`=1 and `pc_we`=1 with `pcsrc`=0 (PC+4), then goes to DECODE.
- DECODE: no strobes asserted. Next state depends on `opcode`:
  - 0110011 (OP), 0010011 (OP-IMM), 0000011 (LOAD), 0100011 (STORE), 1100011 (BRANCH) → EXEC.
  - Any other opcode → TRAP.
- EXEC, by opcode:
  - OP: `alusrc`=0, then WB.
  - OP-IMM and LOAD: `alusrc`=1, `immsrc`=00. OP-IMM → WB, LOAD → MEM.
  - STORE: `alusrc`=1, `immsrc`=01, then MEM.
  - BRANCH: `alusrc`=0, `immsrc`=10.
    - funct3 000 (beq) is taken when `eq`=1; funct3 001 (bne) is taken when `eq`=0.
    - Taken: `pc_we`=1, `pcsrc`=1.
    - Any other funct3 is never taken.
    - Next state is FETCH and the branch retires.
- MEM:
  - Drives `mem_req`=1, with `mem_we`=1 for STORE.
  - Waits for `mem_ready`.
  - LOAD → WB; STORE → FETCH and retires.
- WB:
  - `regwrite`=1; `result_src`=1 for LOAD, otherwise 0.
  - Then FETCH and the instruction retires.
- TRAP: absorbing state; `illegal`=1 and all other strobes 0 until reset.
- All strobes are Moore outputs of (state, opcode, funct3, eq), except that FETCH `ir_we`/`pc_we` are qualified by `mem_ready`.
- Exactly one of `ir_we`, `regwrite`, or taken-branch `pc_we` may be high in any cycle (the FETCH `ir_we`+`pc_we` pair counts as one event).

## Timing
- Cycles per instruction with zero-wait memory (`mem_ready` tied 1):
  - BRANCH 3
  - OP/OP-IMM 4
  - STORE 4
  - LOAD 5
- Each memory wait cycle adds exactly one cycle. `mem_req` stays high and `mem_we` stays stable throughout the wait.
- `retired` increments in the final cycle of the instruction and is visible one cycle later. It wraps from 2^XLEN−1 to 0.
- Reset asserted mid-instruction:
  - Immediate return to START.
  - `mem_req` drops combinationally with reset.
  - No partial `regwrite` or `pc_we` occurs.
  - `illegal` and `retired` clear.
- `mem_ready` high outside FETCH/MEM is ignored.

## Configuration
- `MULTICYCLE_RETIRE_CNT_EN`:
  - Defined: the `retired` counter register is present as specified above.
  - Undefined: `retired` is tied to 0 and no counter flops are synthesized. FSM behaviour is otherwise identical.

## Test plan
- Release reset, `mem_ready`=1, `opcode`=0010011 → states START, FETCH, DECODE, EXEC, WB. `ir_we`/`pc_we` pulse in cycle 2, `alusrc`=1 in EXEC, `regwrite`=1 in WB; `retired`=1 after cycle 5.
- LOAD with `mem_ready` low for 3 cycles in MEM → `mem_req` high for 4 consecutive cycles, `result_src`=1 with `regwrite`=1 in WB; total 8 cycles.
- BRANCH with funct3=001, `eq`=0 → EXEC shows `pc_we`=1, `pcsrc`=1, `immsrc`=10. With `eq`=1 → `pc_we`=0; next state is FETCH in both cases.
- STORE → MEM drives `mem_we`=1 and `immsrc`=01; `regwrite` never asserts; 4 cycles total.
- `opcode`=1111111 → TRAP with `illegal`=1 held for 20 cycles; `rst` low then high → `illegal`=0, FETCH resumes.
- Assert `rst` during a FETCH wait → all outputs 0 in the same cycle, and `retired` returns to 0 when `MULTICYCLE_RETIRE_CNT_EN` is defined.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: shared instruction/data memory req/ready handshake
// master (controller): drives mem_req, mem_we; samples mem_ready
// slave (memory): samples mem_req, mem_we; drives mem_ready
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;
  modport master(output mem_req, output mem_we, input mem_ready);
  modport slave(input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM sequencing fetch/decode/exec/mem/wb over one shared memory port
// ports: clk, rst (async active-low); opcode/funct3/eq from IR and ALU; mem (req/we/ready handshake);
//        ir_we, pc_we, pcsrc, regwrite, alusrc, immsrc, result_src datapath strobes; illegal (sticky); retired count
// MULTICYCLE_RETIRE_CNT_EN: when defined, retired is a live counter; otherwise tied to 0
module multicycle_ctrl #(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             eq,
  multicycle_ctrl_if.master mem,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pcsrc,
  output logic             regwrite,
  output logic             alusrc,
  output logic [1:0]       immsrc,
  output logic             result_src,
  output logic             illegal,
  output logic [XLEN-1:0]  retired
);
  typedef enum logic [2:0] {START, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  state_t state;
  logic is_op, is_imm, is_load, is_store, is_branch, legal, taken;
  assign is_op     = opcode == 7'b0110011;
  assign is_imm    = opcode == 7'b0010011;
  assign is_load   = opcode == 7'b0000011;
  assign is_store  = opcode == 7'b0100011;
  assign is_branch = opcode == 7'b1100011;
  assign legal     = is_op || is_imm || is_load || is_store || is_branch;
  assign taken     = is_branch && ((funct3 == 3'b000 && eq) || (funct3 == 3'b001 && !eq));
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= START;
    else case (state)
      START:   state <= FETCH;
      FETCH:   state <= mem.mem_ready ? DECODE : FETCH;
      DECODE:  state <= legal ? EXEC : TRAP;
      EXEC:    state <= is_branch ? FETCH : (is_load || is_store) ? MEM : WB;
      MEM:     state <= !mem.mem_ready ? MEM : is_load ? WB : FETCH;
      WB:      state <= FETCH;
      default: state <= TRAP;
    endcase
  // strobes decode straight from state so reset forces them low in the same cycle
  assign mem.mem_req = state == FETCH || state == MEM;
  assign mem.mem_we  = state == MEM && is_store;
  assign ir_we       = state == FETCH && mem.mem_ready;
  assign pcsrc       = state == EXEC && taken;
  assign pc_we       = ir_we || pcsrc;
  assign regwrite    = state == WB;
  assign alusrc      = state == EXEC && (is_imm || is_load || is_store);
  // immediate format is held through MEM so the store address stays stable during waits
  assign immsrc      = !(state == EXEC || state == MEM) ? 2'b00 :
                       is_store ? 2'b01 : is_branch ? 2'b10 : 2'b00;
  assign result_src  = state == WB && is_load;
  assign illegal     = state == TRAP;
`ifdef MULTICYCLE_RETIRE_CNT_EN
  logic fire;
  logic [XLEN-1:0] cnt;
  assign fire = (state == EXEC && is_branch) || (state == MEM && is_store && mem.mem_ready) || state == WB;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (fire) cnt <= cnt + 1'b1;
  assign retired = cnt;
`else
  assign retired = '0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
`ifdef MULTICYCLE_RETIRE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic eq = 1'b0;
  logic ir_we, pc_we, pcsrc, regwrite, alusrc, result_src, illegal;
  logic [1:0] immsrc;
  logic [31:0] retired;
  logic [31:0] exp_ret = '0;
  logic [10:0] e;
  int checks = 0;
  int failures = 0;
  multicycle_ctrl_if mif();
  multicycle_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .eq(eq), .mem(mif.master),
    .ir_we(ir_we), .pc_we(pc_we), .pcsrc(pcsrc), .regwrite(regwrite), .alusrc(alusrc),
    .immsrc(immsrc), .result_src(result_src), .illegal(illegal), .retired(retired)
  );
  // {mem_req, mem_we, ir_we, pc_we, pcsrc, regwrite, alusrc, immsrc[1:0], result_src, illegal}
  logic [10:0] outs;
  assign outs = {mif.mem_req, mif.mem_we, ir_we, pc_we, pcsrc, regwrite, alusrc, immsrc, result_src, illegal};
  always #5 clk = ~clk;
  localparam logic [10:0] ZERO = 11'b0_0_0_0_0_0_0_00_0_0;
  localparam logic [10:0] F_RDY = 11'b1_0_1_1_0_0_0_00_0_0;
  localparam logic [10:0] F_WAIT = 11'b1_0_0_0_0_0_0_00_0_0;
  localparam logic [10:0] EX_I = 11'b0_0_0_0_0_0_1_00_0_0;
  localparam logic [10:0] EX_S = 11'b0_0_0_0_0_0_1_01_0_0;
  localparam logic [10:0] EX_BT = 11'b0_0_0_1_1_0_0_10_0_0;
  localparam logic [10:0] EX_BN = 11'b0_0_0_0_0_0_0_10_0_0;
  localparam logic [10:0] M_LD = 11'b1_0_0_0_0_0_0_00_0_0;
  localparam logic [10:0] M_ST = 11'b1_1_0_0_0_0_0_01_0_0;
  localparam logic [10:0] WB_A = 11'b0_0_0_0_0_1_0_00_0_0;
  localparam logic [10:0] WB_L = 11'b0_0_0_0_0_1_0_00_1_0;
  localparam logic [10:0] TRAP = 11'b0_0_0_0_0_0_0_00_0_1;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    e = ZERO; checks++; if (outs !== e) begin failures++; $display("FAIL reset_outs got=%b want=%b", outs, e); end
    checks++; if (retired !== 32'd0) begin failures++; $display("FAIL reset_retired got=%0d want=0", retired); end
    rst = 1'b1;
    mif.mem_ready = 1'b1;
    #1;
    e = ZERO; checks++; if (outs !== e) begin failures++; $display("FAIL start_outs got=%b want=%b", outs, e); end
    step;
  endtask
  task automatic test_op_imm;
    opcode = 7'b0010011;
    #1;
    e = F_RDY; checks++; if (outs !== e) begin failures++; $display("FAIL opimm_fetch got=%b want=%b", outs, e); end
    step;
    e = ZERO; checks++; if (outs !== e) begin failures++; $display("FAIL opimm_decode got=%b want=%b", outs, e); end
    step;
    e = EX_I; checks++; if (outs !== e) begin failures++; $display("FAIL opimm_exec got=%b want=%b", outs, e); end
    step;
    e = WB_A; checks++; if (outs !== e) begin failures++; $display("FAIL opimm_wb got=%b want=%b", outs, e); end
    checks++; if (retired !== (CNT_EN ? exp_ret : 32'd0)) begin failures++; $display("FAIL opimm_ret_early got=%0d want=%0d", retired, exp_ret); end
    exp_ret++;
    step;
    checks++; if (retired !== (CNT_EN ? exp_ret : 32'd0)) begin failures++; $display("FAIL opimm_retired got=%0d want=%0d", retired, exp_ret); end
  endtask
  task automatic test_op;
    opcode = 7'b0110011;
    #1;
    e = F_RDY; checks++; if (outs !== e) begin failures++; $display("FAIL op_fetch got=%b want=%b", outs, e); end
    step;
    step;
    e = ZERO; checks++; if (outs !== e) begin failures++; $display("FAIL op_exec got=%b want=%b", outs, e); end
    step;
    e = WB_A; checks++; if (outs !== e) begin failures++; $display("FAIL op_wb got=%b want=%b", outs, e); end
    exp_ret++;
    step;
    checks++; if (retired !== (CNT_EN ? exp_ret : 32'd0)) begin failures++; $display("FAIL op_retired got=%0d want=%0d", retired, exp_ret); end
  endtask
  task automatic test_load_wait;
    int req_cycles = 0;
    opcode = 7'b0000011;
    #1;
    e = F_RDY; checks++; if (outs !== e) begin failures++; $display("FAIL ld_fetch got=%b want=%b", outs, e); end
    step;
    e = ZERO; checks++; if (outs !== e) begin failures++; $display("FAIL ld_decode_ready_ignored got=%b want=%b", outs, e); end
    step;
    mif.mem_ready = 1'b0;
    #1;
    e = EX_I; checks++; if (outs !== e) begin failures++; $display("FAIL ld_exec got=%b want=%b", outs, e); end
    step;
    for (int i = 0; i < 4; i++) begin
      mif.mem_ready = (i == 3);
      #1;
      if (outs === M_LD) req_cycles++;
      step;
    end
    checks++; if (req_cycles !== 4) begin failures++; $display("FAIL ld_mem_req_cycles got=%0d want=4", req_cycles); end
    e = WB_L; checks++; if (outs !== e) begin failures++; $display("FAIL ld_wb got=%b want=%b", outs, e); end
    exp_ret++;
    step;
    e = F_RDY; checks++; if (outs !== e) begin failures++; $display("FAIL ld_next_fetch got=%b want=%b", outs, e); end
    checks++; if (retired !== (CNT_EN ? exp_ret : 32'd0)) begin failures++; $display("FAIL ld_retired got=%0d want=%0d", retired, exp_ret); end
  endtask
  task automatic test_branch;
    logic [2:0] f3 [4] = '{3'b001, 3'b001, 3'b000, 3'b100};
    logic eqv [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic tk [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      opcode = 7'b1100011;
      funct3 = f3[i];
      eq = eqv[i];
      step;
      step;
      e = tk[i] ? EX_BT : EX_BN; checks++; if (outs !== e) begin failures++; $display("FAIL br_exec%0d got=%b want=%b", i, outs, e); end
      exp_ret++;
      step;
      e = F_RDY; checks++; if (outs !== e) begin failures++; $display("FAIL br_next_fetch%0d got=%b want=%b", i, outs, e); end
      checks++; if (retired !== (CNT_EN ? exp_ret : 32'd0)) begin failures++; $display("FAIL br_retired%0d got=%0d want=%0d", i, retired, exp_ret); end
    end
  endtask
  task automatic test_store;
    int rw = 0;
    opcode = 7'b0100011;
    step;
    step;
    e = EX_S; checks++; if (outs !== e) begin failures++; $display("FAIL st_exec got=%b want=%b", outs, e); end
    step;
    mif.mem_ready = 1'b0;
    #1;
    if (regwrite) rw++;
    e = M_ST; checks++; if (outs !== e) begin failures++; $display("FAIL st_mem_wait got=%b want=%b", outs, e); end
    step;
    mif.mem_ready = 1'b1;
    #1;
    if (regwrite) rw++;
    e = M_ST; checks++; if (outs !== e) begin failures++; $display("FAIL st_mem got=%b want=%b", outs, e); end
    exp_ret++;
    step;
    checks++; if (rw !== 0) begin failures++; $display("FAIL st_regwrite got=%0d want=0", rw); end
    e = F_RDY; checks++; if (outs !== e) begin failures++; $display("FAIL st_next_fetch got=%b want=%b", outs, e); end
    checks++; if (retired !== (CNT_EN ? exp_ret : 32'd0)) begin failures++; $display("FAIL st_retired got=%0d want=%0d", retired, exp_ret); end
  endtask
  task automatic test_reset_mid;
    mif.mem_ready = 1'b0;
    #1;
    e = F_WAIT; checks++; if (outs !== e) begin failures++; $display("FAIL rm_fetch_wait got=%b want=%b", outs, e); end
    step;
    rst = 1'b0;
    #1;
    e = ZERO; checks++; if (outs !== e) begin failures++; $display("FAIL rm_async_outs got=%b want=%b", outs, e); end
    checks++; if (retired !== 32'd0) begin failures++; $display("FAIL rm_retired got=%0d want=0", retired); end
    exp_ret = '0;
    step;
    rst = 1'b1;
    mif.mem_ready = 1'b1;
    step;
    e = F_RDY; checks++; if (outs !== e) begin failures++; $display("FAIL rm_resume got=%b want=%b", outs, e); end
  endtask
  task automatic test_trap;
    int bad = 0;
    opcode = 7'b1111111;
    step;
    step;
    for (int i = 0; i < 20; i++) begin
      mif.mem_ready = i[0];
      #1;
      if (outs !== TRAP) bad++;
      step;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL trap_hold bad_cycles=%0d want=0 last=%b", bad, outs); end
    rst = 1'b0;
    #1;
    e = ZERO; checks++; if (outs !== e) begin failures++; $display("FAIL trap_reset got=%b want=%b", outs, e); end
    exp_ret = '0;
    step;
    rst = 1'b1;
    mif.mem_ready = 1'b1;
    step;
    e = F_RDY; checks++; if (outs !== e) begin failures++; $display("FAIL trap_resume got=%b want=%b", outs, e); end
  endtask
  initial begin
    mif.mem_ready = 1'b1;
    test_reset;
    test_op_imm;
    test_op;
    test_load_wait;
    test_branch;
    test_store;
    test_reset_mid;
    test_trap;
    test_op_imm;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
